// File: rtl/backing_ram.sv
// Backing store behind the cache: 8 words x 8 bits held in registers.
// Each access completes a fixed LATENCY cycles after the request is accepted.
module backing_ram #(
    parameter int LATENCY = 3
) (
    input  logic       clk,
    input  logic       clr,
    input  logic       req,
    input  logic       rw,
    input  logic [7:0] addr,
    input  logic [7:0] data_in,
    output logic [7:0] data_out,
    output logic       ack,
    output logic       busy,
    output logic       err,
    output logic [1:0] state,
    output logic [7:0] ram0,
    output logic [7:0] ram1,
    output logic [7:0] ram2,
    output logic [7:0] ram3,
    output logic [7:0] ram4,
    output logic [7:0] ram5,
    output logic [7:0] ram6,
    output logic [7:0] ram7
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_RESP = 2'd2
    } state_t;

    localparam logic [3:0] CNT_LOAD = 4'(LATENCY - 1);

    state_t      r_state;
    logic [3:0]  r_cnt;
    logic        r_rw;
    logic [7:0]  r_addr;
    logic [7:0]  r_data;
    logic [7:0]  r_dout;
    logic        r_ack;
    logic        r_err;
    logic [7:0]  r_mem [8];

    logic        w_oor;
    logic [2:0]  w_idx;

    // Only words 0..7 exist; any high address bit makes the access out of range.
    assign w_oor = |r_addr[7:3];
    assign w_idx = r_addr[2:0];

    always_ff @(posedge clk) begin
        if (clr) begin
            r_state <= S_IDLE;
            r_cnt   <= 4'd0;
            r_ack   <= 1'b0;
            r_err   <= 1'b0;
            r_dout  <= 8'h00;
            for (int i = 0; i < 8; i++) begin
                r_mem[i] <= 8'h00;
            end
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (req) begin
                        r_rw    <= rw;
                        r_addr  <= addr;
                        r_data  <= data_in;
                        r_cnt   <= CNT_LOAD;
                        r_state <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (r_cnt != 4'd0) begin
                        r_cnt <= r_cnt - 4'd1;
                    end else begin
                        r_ack   <= 1'b1;
                        r_err   <= w_oor;
                        r_state <= S_RESP;
                        if (w_oor) begin
                            if (!r_rw) begin
                                r_dout <= 8'hFF;
                            end
                        end else if (r_rw) begin
                            r_mem[w_idx] <= r_data;
                        end else begin
                            r_dout <= r_mem[w_idx];
                        end
                    end
                end
                S_RESP: begin
                    r_ack   <= 1'b0;
                    r_err   <= 1'b0;
                    r_state <= S_IDLE;
                end
                default: begin
                    r_ack   <= 1'b0;
                    r_err   <= 1'b0;
                    r_cnt   <= 4'd0;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign data_out = r_dout;
    assign ack      = r_ack;
    assign err      = r_err;
    assign state    = r_state;
    assign busy     = (r_state != S_IDLE);
    assign ram0     = r_mem[0];
    assign ram1     = r_mem[1];
    assign ram2     = r_mem[2];
    assign ram3     = r_mem[3];
    assign ram4     = r_mem[4];
    assign ram5     = r_mem[5];
    assign ram6     = r_mem[6];
    assign ram7     = r_mem[7];

endmodule

// File: tb/tb_backing_ram.sv
// Bench for backing_ram: two instances (LATENCY 3 and 1) share stimulus and
// are checked every cycle against a transaction-level model plus literal checks.
module tb_backing_ram;

    localparam int LAT_A = 3;
    localparam int LAT_B = 1;

    logic       clk = 1'b0;
    logic       clr;
    logic       req;
    logic       rw;
    logic [7:0] addr;
    logic [7:0] data_in;

    logic [7:0] dout [2];
    logic       ack  [2];
    logic       busy [2];
    logic       err  [2];
    logic [1:0] st   [2];
    logic [7:0] ram  [2][8];

    int checks   = 0;
    int failures = 0;
    logic cmp_en = 1'b0;

    always #5 clk = ~clk;

    backing_ram #(.LATENCY(LAT_A)) u_a (
        .clk(clk), .clr(clr), .req(req), .rw(rw), .addr(addr), .data_in(data_in),
        .data_out(dout[0]), .ack(ack[0]), .busy(busy[0]), .err(err[0]), .state(st[0]),
        .ram0(ram[0][0]), .ram1(ram[0][1]), .ram2(ram[0][2]), .ram3(ram[0][3]),
        .ram4(ram[0][4]), .ram5(ram[0][5]), .ram6(ram[0][6]), .ram7(ram[0][7])
    );

    backing_ram #(.LATENCY(LAT_B)) u_b (
        .clk(clk), .clr(clr), .req(req), .rw(rw), .addr(addr), .data_in(data_in),
        .data_out(dout[1]), .ack(ack[1]), .busy(busy[1]), .err(err[1]), .state(st[1]),
        .ram0(ram[1][0]), .ram1(ram[1][1]), .ram2(ram[1][2]), .ram3(ram[1][3]),
        .ram4(ram[1][4]), .ram5(ram[1][5]), .ram6(ram[1][6]), .ram7(ram[1][7])
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s at %0t: got %h expected %h", nm, $time, act, exp);
        end
    endtask

    // Transaction-level model: a request is "in flight" for LATENCY edges,
    // completes with a one-cycle ack, then the block is idle one edge later.
    logic       m_busy [2];
    logic       m_ack  [2];
    logic       m_err  [2];
    int         m_t    [2];
    logic       m_w    [2];
    logic [7:0] m_a    [2];
    logic [7:0] m_d    [2];
    logic [7:0] m_dout [2];
    logic [7:0] m_mem  [2][8];

    function automatic int lat_of(input int k);
        return (k == 0) ? LAT_A : LAT_B;
    endfunction

    always @(posedge clk) begin
        for (int k = 0; k < 2; k++) begin
            if (clr) begin
                m_busy[k] = 1'b0;
                m_ack[k]  = 1'b0;
                m_err[k]  = 1'b0;
                m_t[k]    = 0;
                m_dout[k] = 8'h00;
                for (int i = 0; i < 8; i++) m_mem[k][i] = 8'h00;
            end else if (m_ack[k]) begin
                m_ack[k]  = 1'b0;
                m_err[k]  = 1'b0;
                m_busy[k] = 1'b0;
            end else if (m_busy[k]) begin
                m_t[k] = m_t[k] + 1;
                if (m_t[k] == lat_of(k)) begin
                    m_ack[k] = 1'b1;
                    if (m_a[k] > 8'd7) begin
                        m_err[k] = 1'b1;
                        if (!m_w[k]) m_dout[k] = 8'hFF;
                    end else if (m_w[k]) begin
                        m_mem[k][m_a[k][2:0]] = m_d[k];
                    end else begin
                        m_dout[k] = m_mem[k][m_a[k][2:0]];
                    end
                end
            end else if (req) begin
                m_busy[k] = 1'b1;
                m_t[k]    = 0;
                m_w[k]    = rw;
                m_a[k]    = addr;
                m_d[k]    = data_in;
            end
        end
    end

    always @(negedge clk) begin
        if (cmp_en) begin
            for (int k = 0; k < 2; k++) begin
                chk($sformatf("state[%0d]", k), 32'(st[k]),
                    !m_busy[k] ? 32'd0 : (m_ack[k] ? 32'd2 : 32'd1));
                chk($sformatf("busy[%0d]", k), 32'(busy[k]), 32'(m_busy[k]));
                chk($sformatf("ack[%0d]", k), 32'(ack[k]), 32'(m_ack[k]));
                chk($sformatf("err[%0d]", k), 32'(err[k]), 32'(m_err[k]));
                chk($sformatf("data_out[%0d]", k), 32'(dout[k]), 32'(m_dout[k]));
                for (int i = 0; i < 8; i++)
                    chk($sformatf("ram%0d[%0d]", i, k), 32'(ram[k][i]), 32'(m_mem[k][i]));
            end
        end
    end

    // One request; returns edges from acceptance to ack for both instances.
    task automatic txn(input logic w, input logic [7:0] a, input logic [7:0] d,
                       input logic churn, output int lat_a, output int lat_b,
                       output logic err_a);
        @(negedge clk);
        req = 1'b1; rw = w; addr = a; data_in = d;
        @(negedge clk);
        req = 1'b0;
        lat_a = 0;
        lat_b = -1;
        while (!ack[0] && lat_a < 20) begin
            if (churn) begin
                addr    = 8'($urandom);
                data_in = 8'($urandom);
                rw      = 1'($urandom);
            end
            @(negedge clk);
            lat_a++;
            if (ack[1] && lat_b < 0) lat_b = lat_a;
        end
        err_a = err[0];
        @(negedge clk);
    endtask

    int   la, lb;
    logic ea;
    logic hist_ack  [16];
    logic hist_busy [16];
    int   ia, ja;

    initial begin
        clr = 1'b1; req = 1'b0; rw = 1'b0; addr = 8'h00; data_in = 8'h00;
        repeat (2) @(negedge clk);
        chk("reset_state", 32'(st[0]), 32'd0);
        chk("reset_dout", 32'(dout[0]), 32'h00);
        chk("reset_ack", 32'(ack[0]), 32'd0);
        chk("reset_ram1", 32'(ram[0][1]), 32'h00);
        clr = 1'b0;
        cmp_en = 1'b1;

        // Write then read word 1
        txn(1'b1, 8'h01, 8'hE0, 1'b0, la, lb, ea);
        chk("wr_latency", 32'(la), 32'd3);
        chk("wr_latency_b", 32'(lb), 32'd1);
        chk("wr_ram1", 32'(ram[0][1]), 32'hE0);
        txn(1'b0, 8'h01, 8'h00, 1'b0, la, lb, ea);
        chk("rd_latency", 32'(la), 32'd3);
        chk("rd_dout", 32'(dout[0]), 32'hE0);
        chk("rd_err", 32'(ea), 32'd0);

        // Out of range
        txn(1'b1, 8'h10, 8'h55, 1'b0, la, lb, ea);
        chk("oor_wr_err", 32'(ea), 32'd1);
        chk("oor_wr_ram0", 32'(ram[0][0]), 32'h00);
        chk("oor_wr_dout", 32'(dout[0]), 32'hE0);
        txn(1'b0, 8'h80, 8'h00, 1'b0, la, lb, ea);
        chk("oor_rd_err", 32'(ea), 32'd1);
        chk("oor_rd_dout", 32'(dout[0]), 32'hFF);

        // LATENCY = 1 instance: write then read word 7
        txn(1'b1, 8'h07, 8'hC7, 1'b0, la, lb, ea);
        txn(1'b0, 8'h07, 8'h00, 1'b0, la, lb, ea);
        chk("lat1_latency", 32'(lb), 32'd1);
        chk("lat1_dout", 32'(dout[1]), 32'hC7);

        // Input churn during WAIT
        txn(1'b1, 8'h05, 8'h3C, 1'b1, la, lb, ea);
        chk("churn_ram5", 32'(ram[0][5]), 32'h3C);
        txn(1'b0, 8'h05, 8'h00, 1'b1, la, lb, ea);
        chk("churn_dout", 32'(dout[0]), 32'h3C);

        // Held request, alternating addresses
        @(negedge clk);
        req = 1'b1; rw = 1'b1; addr = 8'h02; data_in = 8'h20;
        for (int c = 0; c < 16; c++) begin
            @(negedge clk);
            hist_ack[c]  = ack[0];
            hist_busy[c] = busy[0];
            if (c < 11) begin
                addr    = (addr == 8'h02) ? 8'h03 : 8'h02;
                data_in = data_in + 8'h01;
            end else begin
                req = 1'b0;
            end
        end
        ia = -1; ja = -1;
        for (int c = 0; c < 16; c++) begin
            if (hist_ack[c]) begin
                if (ia < 0) ia = c;
                else if (ja < 0) ja = c;
            end
        end
        chk("held_first_ack", 32'(ia), 32'd3);
        chk("held_ack_gap", 32'(ja - ia), 32'd5);
        if (ia >= 0 && ia < 14) begin
            chk("held_idle_gap", 32'(hist_busy[ia+1]), 32'd0);
            chk("held_rebusy", 32'(hist_busy[ia+2]), 32'd1);
        end
        repeat (3) @(negedge clk);

        // Reset in WAIT aborts the write; first edge with clr low accepts a new req
        req = 1'b1; rw = 1'b1; addr = 8'h04; data_in = 8'h18;
        @(negedge clk);
        req = 1'b0; clr = 1'b1;
        chk("abort_in_wait", 32'(st[0]), 32'd1);
        @(negedge clk);
        clr = 1'b0;
        chk("abort_ack", 32'(ack[0]), 32'd0);
        chk("abort_ram4", 32'(ram[0][4]), 32'h00);
        chk("abort_state", 32'(st[0]), 32'd0);
        req = 1'b1; rw = 1'b0; addr = 8'h04;
        @(negedge clk);
        req = 1'b0;
        chk("post_reset_accept", 32'(st[0]), 32'd1);
        la = 0;
        while (!ack[0] && la < 20) begin
            @(negedge clk);
            la++;
        end
        chk("post_reset_latency", 32'(la), 32'd3);
        chk("post_reset_dout", 32'(dout[0]), 32'h00);
        repeat (2) @(negedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
        $fatal(1, "watchdog");
    end

endmodule
